muldiv_unit: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit alongside the single-cycle ALU in the execute stage.
- Implements the eight RV32M/RV64M operations, one result bit per clock.
- Valid/ready handshakes on both the operand side and the result side.
- ZERO flag output on the result, same meaning as the ALU flag.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M/RV64M multiply/divide, one bit per clock  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] X,
  output logic            ZERO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_op_mul    = 3'b000;
  localparam logic [2:0] c_op_mulh   = 3'b001;
  localparam logic [2:0] c_op_mulhsu = 3'b010;
  localparam logic [2:0] c_op_mulhu  = 3'b011;
  localparam logic [2:0] c_op_div    = 3'b100;
  localparam logic [2:0] c_op_divu   = 3'b101;
  localparam logic [2:0] c_op_rem    = 3'b110;
  localparam logic [2:0] c_op_remu   = 3'b111;

  localparam logic [XLEN-1:0]  c_ones    = '1;
  localparam logic [XLEN-1:0]  c_min     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_steps   = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_main, r_neg_rem;
  logic [XLEN-1:0]   r_x;

  logic              w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]   w_special_x;

  assign w_accept    = in_valid && !flush && (r_state == S_IDLE);
  assign w_is_div    = op[2];
  assign w_a_signed  = (op != c_op_mulhu) && (op != c_op_divu) && (op != c_op_remu);
  assign w_b_signed  = w_a_signed && (op != c_op_mulhsu);
  assign w_a_neg     = w_a_signed && A[XLEN-1];
  assign w_b_neg     = w_b_signed && B[XLEN-1];
  assign w_a_mag     = w_a_neg ? (~A + 1'b1) : A;
  assign w_b_mag     = w_b_neg ? (~B + 1'b1) : B;
  assign w_div_zero  = w_is_div && (B == '0);
  assign w_div_ovf   = w_is_div && !op[0] && (A == c_min) && (B == c_ones);
  assign w_special   = w_div_zero || w_div_ovf;
  assign w_special_x = w_div_zero ? (op[1] ? A : c_ones) : (op[1] ? '0 : A);

  // Accumulator: {hi, lo}. Multiply keeps partial product in hi and the
  // multiplier in lo; divide keeps the partial remainder in hi, dividend/quotient in lo.
  logic [XLEN-1:0]   w_hi, w_lo, w_diff;
  logic [XLEN:0]     w_sum, w_shift;
  logic              w_ge;
  logic [2*XLEN-1:0] w_acc_next, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_result;

  assign w_hi    = r_acc[2*XLEN-1:XLEN];
  assign w_lo    = r_acc[XLEN-1:0];
  assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : '0);
  assign w_shift = {w_hi, w_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_diff  = w_shift[XLEN-1:0] - r_opb;

  always_comb begin
    w_acc_next = {w_sum, w_lo[XLEN-1:1]};
    if (r_op[2]) begin
      if (w_ge) w_acc_next = {w_diff, w_lo[XLEN-2:0], 1'b1};
      else      w_acc_next = {w_shift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
    end
  end

  assign w_prod = r_neg_main ? (~w_acc_next + 1'b1) : w_acc_next;
  assign w_quo  = r_neg_main ? (~w_acc_next[XLEN-1:0] + 1'b1) : w_acc_next[XLEN-1:0];
  assign w_rem  = r_neg_rem ? (~w_acc_next[2*XLEN-1:XLEN] + 1'b1)
                            : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_result = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      c_op_mul:                         w_result = w_prod[XLEN-1:0];
      c_op_mulh, c_op_mulhsu, c_op_mulhu: w_result = w_prod[2*XLEN-1:XLEN];
      c_op_div, c_op_divu:              w_result = w_quo;
      c_op_rem, c_op_remu:              w_result = w_rem;
      default:                          w_result = w_prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_next = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush)                   w_state_next = S_IDLE;
        else if (r_cnt == c_cnt_one) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_x        <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_op       <= op;
        r_neg_main <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= w_a_neg;
        if (w_special) begin
          r_x <= w_special_x;
        end else begin
          r_cnt <= c_steps;
          r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          r_opb <= w_is_div ? w_b_mag : w_a_mag;
        end
      end
    end else if (r_state == S_CALC) begin
      if (flush) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
        r_acc <= w_acc_next;
        if (r_cnt == c_cnt_one) r_x <= w_result;
      end
    end
  end

  assign X    = r_x;
  assign ZERO = out_valid && (r_x == '0);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit : directed + random bench for muldiv_unit (XLEN=32)      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        in_ready, out_valid, ZERO;
  logic [31:0] X;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .X        (X),
    .ZERO     (ZERO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 64-bit signed/unsigned arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ua); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accepting edge before out_valid is seen:
  // 0 for the divide special cases, XLEN for everything else.
  function automatic int ref_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    return 32;
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_x);
    int n;
    start_op(o, a, b);
    wait_valid(n);
    check({tag, ".wait"}, 64'(n), 64'(ref_wait(o, a, b)));
    check({tag, ".x"}, {32'b0, X}, {32'b0, exp_x});
    check({tag, ".zero"}, {63'b0, ZERO}, {63'b0, exp_x == 0});
    handoff();
  endtask

  initial begin
    int n, vcount;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; A = '0; B = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    check("rst.in_ready", {63'b0, in_ready}, 64'd1);
    check("rst.out_valid", {63'b0, out_valid}, 64'd0);
    check("rst.x", {32'b0, X}, 64'd0);
    check("rst.zero", {63'b0, ZERO}, 64'd0);

    // MUL with immediate consumer; in_ready returns after the handoff edge
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul.busy", {63'b0, in_ready}, 64'd0);
    wait_valid(n);
    check("mul.wait", 64'(n), 64'd32);
    check("mul.x", {32'b0, X}, 64'hFFFF_FFEB);
    check("mul.zero", {63'b0, ZERO}, 64'd0);
    handoff();
    check("mul.in_ready_after", {63'b0, in_ready}, 64'd1);
    check("mul.out_valid_after", {63'b0, out_valid}, 64'd0);

    run_check("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_check("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_check("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_check("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_check("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    run_check("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_check("rem0", 3'd6, 32'd5, 32'd0, 32'd5);
    run_check("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_check("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Backpressure: result held, new request ignored until after handoff
    start_op(3'd5, 32'd100, 32'd7);
    wait_valid(n);
    op = 3'd3; A = 32'h1234_5678; B = 32'h9ABC_DEF0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.x", {32'b0, X}, 64'd14);
      check("bp.zero", {63'b0, ZERO}, 64'd0);
      check("bp.in_ready", {63'b0, in_ready}, 64'd0);
      check("bp.out_valid", {63'b0, out_valid}, 64'd1);
    end
    handoff();
    check("bp.out_valid_after", {63'b0, out_valid}, 64'd0);
    check("bp.in_ready_after", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.accepted", {63'b0, in_ready}, 64'd0);
    wait_valid(n);
    check("bp.second.wait", 64'(n), 64'd32);
    check("bp.second.x", {32'b0, X}, {32'b0, ref_result(3'd3, 32'h1234_5678, 32'h9ABC_DEF0)});
    handoff();

    // Flush in IDLE suppresses acceptance
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; A = 32'd1; B = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle.in_ready", {63'b0, in_ready}, 64'd1);

    // Flush on the 10th CALC cycle of a DIV
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.in_ready", {63'b0, in_ready}, 64'd1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      vcount += int'(out_valid);
      @(posedge clk); #1;
    end
    check("flush.no_valid", 64'(vcount), 64'd0);

    // Reset mid-CALC
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstcalc.in_ready", {63'b0, in_ready}, 64'd1);
    check("rstcalc.x", {32'b0, X}, 64'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      vcount += int'(out_valid);
      @(posedge clk); #1;
    end
    check("rstcalc.no_valid", 64'(vcount), 64'd0);

    run_check("mul34", 3'd0, 32'd3, 32'd4, 32'd12);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_check($sformatf("rand%0d", i), ro, ra, rb, ref_result(ro, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
